sub_shift_rows: RTL
===================

# sub_shift_rows

Iterative AES SubBytes + ShiftRows stage. It sits directly upstream of the MixColumns stage and drives that stage's `valid_in`/`data_in` pair. The block accepts one 128-bit state, substitutes it through four shared S-box instances one column per cycle, applies ShiftRows, and presents the result with a one-cycle valid pulse.

## Interface
Parameters:
- DATA_LEN, 128, state width in bits; only 128 is supported.

Ports:
- clk  input  1  clock; all state changes occur on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_in  input  1  input state valid; accepted only when `ready` = 1.
- data_in  input  DATA_LEN  input state.
- ready  output  1  block idle and able to accept; combinational decode of FSM == IDLE.
- valid_out  output  1  one-cycle pulse; `data_out` holds a new result.
- data_out  output  DATA_LEN  SubBytes+ShiftRows result; held until the next completion.

## Operation
- Byte numbering:
  - byte i = data_in[(15-i)*8+7 : (15-i)*8], so byte 0 is the MSB byte.
  - Layout is column-major: row r = i mod 4, column c = i div 4, i = r + 4c.
  - data_out uses the same numbering.
- Internal storage:
  - 128-bit working register `st`.
  - 2-bit column counter `col`.
  - FSM with states IDLE and SUB.
- Four combinational S-box instances, forward AES S-box per FIPS-197, each 256-entry ROM. They are indexed by bytes 4*col .. 4*col+3 of `st`.
- IDLE:
  - `ready` = 1.
  - On valid_in = 1: `st` <= data_in, `col` <= 0, go to SUB.
  - Otherwise stay; `st` is unchanged.
- SUB:
  - `ready` = 0.
  - Each cycle, bytes 4*col..4*col+3 of `st` are replaced by their S-box values, and `col` <= col + 1.
  - When col == 3, the cycle also:
    - loads data_out <= ShiftRows(st with column 3 substituted);
    - sets valid_out <= 1;
    - returns the FSM to IDLE.
  - `col` wraps 3 -> 0.
- ShiftRows: out byte (r, c) = substituted byte (r, (c + r) mod 4). Row 0 is unshifted; rows 1/2/3 rotate left by 1/2/3 columns.
- valid_out is 0 on every cycle other than the completion cycle.
- valid_in while `ready` = 0 is ignored. There is no queueing, and `st` is not disturbed. The upstream stage must hold or retry.
- No backpressure from downstream: the MixColumns stage consumes on the valid_out cycle unconditionally.

## Timing
- Reset (reset = 0, asynchronous):
  - FSM = IDLE, `col` = 0, `st` = 0.
  - valid_out = 0, data_out = 0, ready = 1.
- Reset mid-SUB aborts the block. No valid_out is produced for the aborted state, and data_out returns to 0.
- Latency and throughput:
  - Accept edge E0; column substitutions occur on E1, E2, E3, E4.
  - valid_out = 1 and data_out is valid in the cycle following E4, so latency is 4 clocks from accept.
  - `ready` returns to 1 in that same cycle. A valid_in present then is accepted on E5 and coexists with valid_out = 1.
  - Maximum throughput is 1 state per 5 clocks.
- data_out changes only on a completion edge. It is stable for at least 5 cycles between pulses.
- valid_in sampled low in IDLE: no change to any register.

## Test plan
- Reset and idle:
  - Assert reset = 0 mid-cycle -> immediately valid_out = 0, data_out = 0, ready = 1.
  - Release reset, hold valid_in = 0 for 10 cycles -> outputs unchanged.
- FIPS-197 Appendix B, round 1:
  - data_in = 193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: exactly 4 clocks after accept, one valid_out pulse with data_out = d4bf5d30e0b452aeb84111f11e2798e5.
  - ready = 0 during the 4 SUB cycles.
- All-zero input:
  - data_in = 0 -> data_out = 636363...63 (16 bytes).
  - Single byte: data_in = 53000000...00 -> data_out byte 0 = ed, all others 63.
- Ignored input while busy:
  - Accept A = 193de3be..., then drive valid_in = 1 with B = all-ones during SUB.
  - Required: result equals the A vector above; B is not captured.
- Back-to-back:
  - Hold valid_in = 1 continuously with A then B = 00..00.
  - Required: valid_out pulses exactly 5 cycles apart; first pulse = A result, second = 6363...63.
  - B is accepted on the same cycle as A's valid_out.
- Reset mid-operation:
  - Accept A, assert reset = 0 after E2, release.
  - Required: no valid_out for A; data_out = 0.
  - A subsequent fresh accept of A produces the correct result 4 clocks later.

Source files
------------

// File: rtl/sub_shift_rows_if.sv
// Handshake bundle between the upstream producer and the SubBytes+ShiftRows stage.
// The master drives the state in; the slave returns ready and the one-cycle result pulse.
interface sub_shift_rows_if #(
  parameter int DATA_LEN = 128
);
  logic                valid_in;
  logic [DATA_LEN-1:0] data_in;
  logic                ready;
  logic                valid_out;
  logic [DATA_LEN-1:0] data_out;

  modport master (
    output valid_in, data_in,
    input  ready, valid_out, data_out
  );

  modport slave (
    input  valid_in, data_in,
    output ready, valid_out, data_out
  );
endinterface

// File: rtl/sub_shift_rows.sv
// Iterative AES SubBytes + ShiftRows: one column per clock through four shared S-boxes,
// then ShiftRows on the final column cycle and a one-cycle valid_out pulse.
module sub_shift_rows #(
  parameter int DATA_LEN = 128
) (
  input logic           clk,
  input logic           reset,
  sub_shift_rows_if.slave bus
);
  typedef enum logic {IDLE, SUB} state_t;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t         state_reg;
  logic [127:0]   st_reg;
  logic [1:0]     col_reg;
  logic [127:0]   data_out_reg;
  logic           valid_out_reg;

  logic [7:0]     sbox_in  [4];
  logic [7:0]     sbox_out [4];
  logic [127:0]   st_next;
  logic [127:0]   shifted_next;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      assign sbox_in[gi]  = st_reg[8*(15 - (4*int'(col_reg) + gi)) +: 8];
      assign sbox_out[gi] = SBOX[8*(255 - int'(sbox_in[gi])) +: 8];
    end
  endgenerate

  always_comb begin
    st_next = st_reg;
    for (int k = 0; k < 4; k++) begin
      st_next[8*(15 - (4*int'(col_reg) + k)) +: 8] = sbox_out[k];
    end
  end

  // Output byte (r,c) takes substituted byte (r,(c+r) mod 4); pure wiring.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_shift
      localparam int R   = gi % 4;
      localparam int C   = gi / 4;
      localparam int SRC = R + 4*((C + R) % 4);
      assign shifted_next[8*(15-gi) +: 8] = st_next[8*(15-SRC) +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      st_reg        <= '0;
      col_reg       <= 2'd0;
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
    end else begin
      valid_out_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.valid_in) begin
            st_reg    <= bus.data_in;
            col_reg   <= 2'd0;
            state_reg <= SUB;
          end
        end
        SUB: begin
          st_reg  <= st_next;
          col_reg <= col_reg + 2'd1;
          if (col_reg == 2'd3) begin
            data_out_reg  <= shifted_next;
            valid_out_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ready     = (state_reg == IDLE);
  assign bus.valid_out = valid_out_reg;
  assign bus.data_out  = data_out_reg;
endmodule
